// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode buffer for the RV32I core.
// Captures the PC of each issued fetch, pairs it with the instruction word
// that the synchronous instruction memory returns one cycle later, and queues
// the pair for decode behind a valid/ready handshake. fetch_ready is the
// credit back to the fetch stage (pc_en).
// Optional build macro IFQ_MISALIGN_EN: when defined, fetches with
// pc[1:0] != 0 are queued as NOP entries flagged with id_misalign.
module if_id_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_pc,
  input  logic [31:0]              imem_rdata,
  output logic                     fetch_ready,
  input  logic                     flush,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_instr,
  output logic                     id_misalign,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_CX = (CW+1)'(DEPTH);

  // In-flight stage: the fetch issued last cycle, waiting for its rdata.
  logic        inflight_v_q, inflight_v_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
`ifdef IFQ_MISALIGN_EN
  logic        inflight_mis_q, inflight_mis_d;
`endif

  // Queue state.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  // Entry storage.
  logic [31:0] mem_pc_q    [DEPTH];
  logic [31:0] mem_pc_d    [DEPTH];
  logic [31:0] mem_instr_q [DEPTH];
  logic [31:0] mem_instr_d [DEPTH];
`ifdef IFQ_MISALIGN_EN
  logic        mem_mis_q   [DEPTH];
  logic        mem_mis_d   [DEPTH];
`endif

  // Handshake and bookkeeping terms.
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          ovf_set;
  logic [31:0]   push_instr;
  logic [CW:0]   occupancy;

  // Capture the issued fetch; a flush kills whatever is being fetched now.
  always_comb begin
    inflight_v_d  = fetch_valid && !flush;
    inflight_pc_d = fetch_pc;
`ifdef IFQ_MISALIGN_EN
    inflight_mis_d = fetch_valid && (fetch_pc[1:0] != 2'b00);
`endif
  end

  // Push/pop decisions, credit computation and head presentation.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_C);
    id_valid = !empty;
    pop      = id_valid && id_ready;
    push_req = inflight_v_q;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push     = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;

`ifdef IFQ_MISALIGN_EN
    push_instr = inflight_mis_q ? NOP_INSTR : imem_rdata;
`else
    push_instr = imem_rdata;
`endif

    // Credit counts the in-flight fetch as already occupying a slot.
    occupancy   = {1'b0, count_q} + (CW+1)'(inflight_v_q) - (CW+1)'(pop);
    fetch_ready = reset || flush || (occupancy < DEPTH_CX);

    if (id_valid) begin
      id_pc    = mem_pc_q[rd_ptr_q];
      id_instr = mem_instr_q[rd_ptr_q];
    end else begin
      id_pc    = 32'h0;
      id_instr = NOP_INSTR;
    end
`ifdef IFQ_MISALIGN_EN
    id_misalign = id_valid && mem_mis_q[rd_ptr_q];
`else
    id_misalign = 1'b0;
`endif

    count   = count_q;
    ovf_err = ovf_q;
  end

  // Next pointer/count/overflow state; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      if (ovf_set) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Write the new entry at the tail.
  always_comb begin
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
`ifdef IFQ_MISALIGN_EN
    mem_mis_d   = mem_mis_q;
`endif
    if (push && !flush) begin
      mem_pc_d[wr_ptr_q]    = inflight_pc_q;
      mem_instr_d[wr_ptr_q] = push_instr;
`ifdef IFQ_MISALIGN_EN
      mem_mis_d[wr_ptr_q]   = inflight_mis_q;
`endif
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= 32'h0;
`ifdef IFQ_MISALIGN_EN
      inflight_mis_q <= 1'b0;
`endif
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= 32'h0;
        mem_instr_q[i] <= NOP_INSTR;
`ifdef IFQ_MISALIGN_EN
        mem_mis_q[i]   <= 1'b0;
`endif
      end
    end else begin
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
`ifdef IFQ_MISALIGN_EN
      inflight_mis_q <= inflight_mis_d;
`endif
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
`ifdef IFQ_MISALIGN_EN
      mem_mis_q   <= mem_mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_if_id_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] imem_rdata;
  logic        fetch_ready;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_misalign;
  logic [2:0]  count;
  logic        ovf_err;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .imem_rdata  (imem_rdata),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_misalign (id_misalign),
    .count       (count),
    .ovf_err     (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  // Reference model: scoreboard queue of entries decode should see, in order.
  ent_t        sb_q[$];
  logic        m_infl_v;
  logic [31:0] m_infl_pc;
  logic        m_ovf;
  int          errors;
  int          checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model mid-cycle, then advance the model
  // by what the upcoming clock edge should do.
  initial begin
    sb_q.delete();
    m_infl_v  = 1'b0;
    m_infl_pc = 32'h0;
    m_ovf     = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("fetch_ready_in_reset", 32'(fetch_ready), 32'd1);
        sb_q.delete();
        m_infl_v = 1'b0;
        m_ovf    = 1'b0;
      end else begin
        bit   exp_pop;
        bit   exp_fr;
        bit   was_full;
        int   occ;
        ent_t e;
        exp_pop = (sb_q.size() > 0) && (id_ready === 1'b1);
        occ     = sb_q.size() + int'(m_infl_v) - int'(exp_pop);
        exp_fr  = (flush === 1'b1) || (occ < DEPTH);
        chk("id_valid", 32'(id_valid), 32'(sb_q.size() > 0));
        if (sb_q.size() > 0) begin
          chk("id_pc", id_pc, sb_q[0].pc);
          chk("id_instr", id_instr, sb_q[0].instr);
          chk("id_misalign", 32'(id_misalign), 32'(sb_q[0].mis));
        end else begin
          chk("empty_id_pc", id_pc, 32'h0);
          chk("empty_id_instr", id_instr, NOP);
          chk("empty_id_misalign", 32'(id_misalign), 32'd0);
        end
        chk("count", 32'(count), 32'(sb_q.size()));
        chk("fetch_ready", 32'(fetch_ready), 32'(exp_fr));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));

        if (flush) begin
          sb_q.delete();
          m_infl_v = 1'b0;
        end else begin
          was_full = (sb_q.size() == DEPTH);
          if (exp_pop) void'(sb_q.pop_front());
          if (m_infl_v) begin
            if (!was_full || exp_pop) begin
              e.pc = m_infl_pc;
`ifdef IFQ_MISALIGN_EN
              e.mis = (m_infl_pc[1:0] != 2'b00);
`else
              e.mis = 1'b0;
`endif
              e.instr = e.mis ? NOP : imem_rdata;
              sb_q.push_back(e);
            end else begin
              m_ovf = 1'b1;
            end
          end
          m_infl_v  = fetch_valid;
          m_infl_pc = fetch_pc;
        end
      end
    end
  end

  task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] rd,
                      input logic rdy, input logic fl);
    fetch_valid = fv;
    fetch_pc    = pc;
    imem_rdata  = rd;
    id_ready    = rdy;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Fetch only while credit is available, decode stalled.
  task automatic fill(input int cycles, input logic [31:0] base);
    logic [31:0] pc;
    pc = base;
    for (int i = 0; i < cycles; i++) begin
      id_ready   = 1'b0;
      flush      = 1'b0;
      imem_rdata = $urandom;
      fetch_pc   = pc;
      #1;
      fetch_valid = fetch_ready;
      if (fetch_ready) pc = pc + 32'd4;
      @(posedge clk);
      #1;
    end
    fetch_valid = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    fetch_valid = 1'b0;
    fetch_pc    = 32'h0;
    imem_rdata  = 32'h0;
    flush       = 1'b0;
    id_ready    = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: streaming fetches with decode always ready.
    step(1'b1, 32'h0, 32'h0,        1'b1, 1'b0);
    step(1'b1, 32'h4, 32'h00500093, 1'b1, 1'b0);
    step(1'b1, 32'h8, 32'h00100113, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h002081B3, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0,        1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0,        1'b1, 1'b0);

    // 2: fill with decode stalled, then release.
    fill(8, 32'h40);
    chk("filled_count", 32'(count), 32'd4);
    chk("filled_no_ovf", 32'(ovf_err), 32'd0);
    id_ready = 1'b1;
    #1;
    chk("credit_reassert", 32'(fetch_ready), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // 3: three queued + one in flight, flush with a concurrent fetch.
    do_reset();
    step(1'b1, 32'h10, 32'h0,        1'b0, 1'b0);
    step(1'b1, 32'h14, 32'h11111111, 1'b0, 1'b0);
    step(1'b1, 32'h18, 32'h22222222, 1'b0, 1'b0);
    step(1'b1, 32'h1C, 32'h33333333, 1'b0, 1'b0);
    step(1'b1, 32'h20, 32'h44444444, 1'b0, 1'b1);
    step(1'b1, 32'h100, 32'h55555555, 1'b0, 1'b0);
    step(1'b0, 32'h0,  32'h00000513, 1'b0, 1'b0);
    step(1'b0, 32'h0,  32'h0,        1'b1, 1'b0);
    step(1'b0, 32'h0,  32'h0,        1'b1, 1'b0);

    // 4: forced fetch into a full queue, sticky overflow across flush.
    do_reset();
    fill(6, 32'h200);
    step(1'b1, 32'h300, 32'h0,        1'b0, 1'b0);
    step(1'b0, 32'h0,   32'hABCDEF01, 1'b0, 1'b0);
    step(1'b0, 32'h0,   32'h0,        1'b0, 1'b1);
    step(1'b0, 32'h0,   32'h0,        1'b1, 1'b0);
    chk("ovf_sticky_after_flush", 32'(ovf_err), 32'd1);
    do_reset();
    chk("ovf_cleared_by_reset", 32'(ovf_err), 32'd0);

    // 5: full queue with push and pop every cycle across pointer wrap.
    fill(6, 32'h400);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h500 + 32'(i * 4), $urandom, 1'b1, 1'b0);
    end
    step(1'b0, 32'h0, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // 6: misaligned PC.
    step(1'b1, 32'h6, 32'h0,        1'b0, 1'b0);
    step(1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0,        1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0,        1'b1, 1'b0);

    // Random traffic, including rare flushes, mid-operation resets and
    // occasional fetches that ignore the credit.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 499) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      id_ready   = ($urandom_range(0, 9) < 6);
      fetch_pc   = $urandom;
      imem_rdata = $urandom;
      #1;
      if (fetch_ready) fetch_valid = ($urandom_range(0, 9) < 7);
      else             fetch_valid = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
    end
    reset       = 1'b0;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
